// File: rtl/cla_seq_adder.sv
// Serial multi-slice adder: one Width-bit carry-lookahead adder walks the operand
// slices LSB first, chaining the slice carry through a register.

module cla #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             ci,
  output logic [Width-1:0] sum,
  output logic             co
);

  localparam int unsigned Groups = Width / 4;

  logic [Groups:0] gc;

  assign gc[0] = ci;

  // Full lookahead inside each 4-bit group; group carries chain between groups.
  for (genvar gi = 0; gi < Groups; gi++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a[gi*4 +: 4] & b[gi*4 +: 4];
    assign p    = a[gi*4 +: 4] ^ b[gi*4 +: 4];
    assign c[0] = gc[gi];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum[gi*4 +: 4] = p ^ c[3:0];
    assign gc[gi+1]       = c[4];
  end

  assign co = gc[Groups];

endmodule

module cla_seq_adder #(
  parameter int unsigned Width = 8,
  parameter int unsigned Words = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Width*Words-1:0] A,
  input  logic [Width*Words-1:0] B,
  input  logic                   CI,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Width*Words-1:0] S,
  output logic                   CO
);

  localparam int unsigned TotW = Width * Words;
  localparam int unsigned CntW = (Words > 1) ? $clog2(Words) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [TotW-1:0]   a_q;
  logic [TotW-1:0]   b_q;
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;
  logic [Width-1:0]  a_sl;
  logic [Width-1:0]  b_sl;
  logic [Width-1:0]  sum_sl;
  logic              co_sl;
  logic              last;

  assign last = (cnt_q == CntW'(Words - 1));

  // Select the captured operand slice addressed by cnt.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < int'(Words); i++) begin
      if (cnt_q == CntW'(i)) begin
        a_sl = a_q[i*Width +: Width];
        b_sl = b_q[i*Width +: Width];
      end
    end
  end

  cla #(.Width(Width)) u_cla (
    .a   (a_sl),
    .b   (b_sl),
    .ci  (carry_q),
    .sum (sum_sl),
    .co  (co_sl)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      S         <= '0;
      CO        <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= CI;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(Words); i++) begin
            if (cnt_q == CntW'(i)) S[i*Width +: Width] <= sum_sl;
          end
          carry_q <= co_sl;
          if (last) CO <= co_sl;
          else      cnt_q <= cnt_q + CntW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder (Width=8, Words=4): the driver queues the
// expected sum at acceptance, a negedge monitor checks latency and the result.

module tb_cla_seq_adder;

  localparam int unsigned Width = 8;
  localparam int unsigned Words = 4;
  localparam int unsigned TotW  = Width * Words;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [TotW-1:0] A;
  logic [TotW-1:0] B;
  logic            CI;
  logic            out_valid;
  logic            out_ready;
  logic [TotW-1:0] S;
  logic            CO;

  typedef struct {
    logic [TotW-1:0] s;
    logic            co;
    int              acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic ov_prev = 1'b0;

  cla_seq_adder #(.Width(Width), .Words(Words)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CI        (CI),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .CO        (CO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on each rising out_valid, result on each handshake.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      else               chk("latency", 64'(cyc - q[0].acc), 64'(Words));
    end
    if (out_valid && out_ready && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sum", 64'(S), 64'(e.s));
      chk("carry_out", 64'(CO), 64'(e.co));
    end
    ov_prev = out_valid;
  end

  // Offer an operand set (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic issue(input logic [TotW-1:0] a, input logic [TotW-1:0] b, input logic ci,
                       input logic [TotW-1:0] es, input logic eco, input bit push,
                       input bit keep_valid, output int acc_cyc);
    int n;
    exp_t e;
    in_valid = 1'b1;
    A = a;
    B = b;
    CI = ci;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    acc_cyc = -1;
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      acc_cyc = cyc + 1;
      if (push) begin
        e.s = es;
        e.co = eco;
        e.acc = acc_cyc;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int prev_acc;
    logic [TotW-1:0] snap_s;
    logic            snap_co;
    logic [TotW-1:0] va[4];
    logic [TotW-1:0] vb[4];
    logic            vc[4];
    logic [TotW:0]   ref_sum;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    CI = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_s", 64'(S), 64'd0);
    chk("reset_co", 64'(CO), 64'd0);

    // Carry out of the low slice.
    issue(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b1, 1'b0, acc);
    drain();

    // Carry-in ripples through every slice.
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, acc);
    drain();

    // Inputs scrambled while running must not disturb the result.
    issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 2; k++) begin
      A = $urandom;
      B = $urandom;
      CI = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Hold the result in DONE with out_ready low.
    out_ready = 1'b0;
    issue(32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1, 1'b1, 1'b0, acc);
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    snap_s = S;
    snap_co = CO;
    chk("hold_snap_s", 64'(snap_s), 64'h00000001);
    chk("hold_snap_co", 64'(snap_co), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_s", 64'(S), 64'(snap_s));
      chk("hold_co", 64'(CO), 64'(snap_co));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    drain();

    // Reset mid-operation while cnt==2.
    issue(32'h01010101, 32'h02020202, 1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_s", 64'(S), 64'd0);
    chk("midreset_co", 64'(CO), 64'd0);
    issue(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b0, acc);
    drain();

    // Back-to-back operands with in_valid and out_ready held high.
    va[0] = 32'hFFFF0000; vb[0] = 32'h0000FFFF; vc[0] = 1'b1;
    va[1] = 32'h7FFFFFFF; vb[1] = 32'h00000001; vc[1] = 1'b0;
    va[2] = 32'hAAAAAAAA; vb[2] = 32'h55555555; vc[2] = 1'b0;
    va[3] = 32'hDEADBEEF; vb[3] = 32'h11111111; vc[3] = 1'b0;
    prev_acc = -1;
    for (int k = 0; k < 4; k++) begin
      ref_sum = 33'(va[k]) + 33'(vb[k]) + 33'(vc[k]);
      issue(va[k], vb[k], vc[k], ref_sum[TotW-1:0], ref_sum[TotW], 1'b1, (k < 3), acc);
      if (prev_acc >= 0) chk("throughput", 64'(acc - prev_acc), 64'(Words + 2));
      prev_acc = acc;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 The block SHALL have parameter Width, default 8, giving the slice width in bits; it must be a multiple of 4.
REQ-002 The block SHALL have parameter Words, default 4, giving the number of slices per operand; it must be at least 2.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset; reset is synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit, SHALL mean that an operand set is offered.
REQ-006 Port in_ready, output, 1 bit, SHALL mean that the block accepts an operand set this cycle.
REQ-007 Port A, input, Width*Words bits, SHALL be operand A.
REQ-008 Port B, input, Width*Words bits, SHALL be operand B.
REQ-009 Port CI, input, 1 bit, SHALL be the carry-in to the least significant slice.
REQ-010 Port out_valid, output, 1 bit, SHALL mean that the result is valid.
REQ-011 Port out_ready, input, 1 bit, SHALL mean that the consumer takes the result this cycle.
REQ-012 Port S, output, Width*Words bits, SHALL be the registered sum.
REQ-013 Port CO, output, 1 bit, SHALL be the registered carry-out of the most significant slice.

Function
REQ-014 The block SHALL compute {CO,S} = A + B + CI serially, using exactly one instance of the team's Width-bit carry-lookahead adder (cla) plus a carry register.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE) and be driven from registers.
REQ-017 IDLE: on in_valid&&in_ready, the block SHALL capture A, B and CI into internal registers, clear slice counter cnt to 0, and go to RUN.
REQ-018 RUN, each cycle: the cla SHALL add slice cnt of the captured A and B with the carry register; the sum SHALL be written to S[cnt*Width +: Width] and the carry register updated with the slice carry-out.
REQ-019 RUN: cnt SHALL increment by 1 each cycle; in the cycle where cnt==Words-1, the block SHALL write the final carry to CO and go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly Words cycles after the acceptance edge.
REQ-021 DONE: S, CO and out_valid SHALL hold until out_valid&&out_ready; on that edge the block SHALL go to IDLE.
REQ-022 No acceptance SHALL occur in the DONE-to-IDLE handshake cycle, so sustained throughput SHALL be one operation per Words+2 cycles.
REQ-023 Changes on A, B, CI or in_valid during RUN or DONE SHALL have no effect on the result.
REQ-024 out_ready asserted outside DONE SHALL be ignored.
REQ-025 S and CO SHALL retain the last result after the handshake, until the first RUN slice write of the next operation.
REQ-026 S slices above cnt SHALL hold stale values during RUN; only out_valid qualifies S.
REQ-027 Wrap-around: the sum SHALL be modulo 2^(Width*Words), with the overflow bit reported only on CO.
REQ-028 cnt SHALL be ceil(log2(Words)) bits wide, or 1 bit minimum, and SHALL never exceed Words-1.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL set state=IDLE, cnt=0, the carry register to 0, S=0, CO=0 and the captured operands to 0; consequently in_ready=1 and out_valid=0 in the following cycle.
REQ-030 rst SHALL take priority over every handshake, including in the RUN or DONE state; the in-progress operation is discarded and no out_valid is produced for it.
REQ-031 The first operation after reset SHALL complete with REQ-020 latency and a correct result.

Verification (Width=8, Words=4)
REQ-032 A=0x000000FF, B=0x00000001, CI=0 -> out_valid 4 cycles after acceptance, S=0x00000100, CO=0.
REQ-033 A=0xFFFFFFFF, B=0x00000000, CI=1 -> S=0x00000000, CO=1 (carry ripples through all four slices).
REQ-034 A=0x12345678, B=0x9ABCDEF0, CI=0 -> S=0xACF13568, CO=0; A and B driven to random values during RUN -> result unchanged.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid=1, S and CO stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-036 Assert rst for one cycle while cnt==2 in RUN -> next cycle in_ready=1, out_valid=0, S=0, CO=0; a subsequent A=0x00000001, B=0x00000001 -> S=0x00000002.
REQ-037 in_valid and out_ready held at 1 with back-to-back operands -> one acceptance every 6 cycles, each result correct against a reference model.
